mem_data_responder: RTL and testbench

MEM_DATA_RESPONDER -- requirements
Module: mem_data_responder

---
 rtl/mem_resp_pkg.sv | 43 ++++
 rtl/mem_resp_lane_unit.sv | 54 +++++
 rtl/mem_data_responder.sv | 119 +++++++++++
 tb/tb_mem_data_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory data responder.
// Load-mode encodings, FSM states and byte-lane select helpers.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      MODE_WORD   = 2'b00,
      MODE_HALF_S = 2'b01,
      MODE_BYTE_S = 2'b10,
      MODE_BYTE_U = 2'b11
   } load_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   localparam int CNT_W  = 4;
   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;

   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_BYTE = 4'b0001;

   // Address bits below the access width are ignored when picking lanes.
   function automatic logic [3:0] lane_enable(input load_mode_e mode, input logic [1:0] addr_lo);
      case (mode)
         MODE_WORD:   return BE_WORD;
         MODE_HALF_S: return addr_lo[1] ? (BE_HALF << 2) : BE_HALF;
         default:     return BE_BYTE << addr_lo;
      endcase
   endfunction

   function automatic logic misaligned(input load_mode_e mode, input logic [1:0] addr_lo);
      case (mode)
         MODE_WORD:   return addr_lo != 2'b00;
         MODE_HALF_S: return addr_lo[0];
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_resp_lane_unit.sv
// Combinational byte-lane unit: load extraction/extension and store
// byte-enable merge into the addressed word.
module mem_resp_lane_unit
   import mem_resp_pkg::*;
(
   input  load_mode_e  mode,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] mem_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [3:0]        be;
   logic [31:0]       store_rep;
   logic [HALF_W-1:0] lane_half;
   logic [BYTE_W-1:0] lane_byte;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
      be          = lane_enable(mode, addr_lo);
      lane_half   = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
      lane_byte   = mem_word[{addr_lo, 3'b000} +: BYTE_W];
      load_data   = mem_word;
      store_rep   = store_data;
      merged_word = mem_word;

      case (mode)
         MODE_WORD: begin
            load_data = mem_word;
            store_rep = store_data;
         end
         MODE_HALF_S: begin
            load_data = {{HALF_W{lane_half[HALF_W-1]}}, lane_half};
            store_rep = {2{store_data[HALF_W-1:0]}};
         end
         MODE_BYTE_S: begin
            load_data = {{(32-BYTE_W){lane_byte[BYTE_W-1]}}, lane_byte};
            store_rep = {4{store_data[BYTE_W-1:0]}};
         end
         default: begin
            load_data = {{(32-BYTE_W){1'b0}}, lane_byte};
            store_rep = {4{store_data[BYTE_W-1:0]}};
         end
      endcase

      // Right-aligned store data is replicated to every lane, then masked in.
      for (int i = 0; i < 4; i++) begin
         merged_word[BYTE_W*i +: BYTE_W] = be[i] ? store_rep[BYTE_W*i +: BYTE_W]
                                                 : mem_word[BYTE_W*i +: BYTE_W];
      end
   end

endmodule

// File: rtl/mem_data_responder.sv
// Single-port word memory behind a valid/ready request and one-cycle response pulse.
// Define MEM_RESP_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module mem_data_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_load_mode,
   input  logic [31:0] req_address,
   input  logic [31:0] req_write_data,
   output logic        resp_valid,
   output logic [31:0] resp_read_data,
   output logic        resp_error
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

   state_e            state;
   state_e            next_state;
   logic [CNT_W-1:0]  cnt;
   logic              h_write;
   load_mode_e        h_mode;
   logic [31:0]       h_addr;
   logic [31:0]       h_wdata;
   logic [31:0]       held_rdata;
   logic [31:0]       mem [DEPTH_WORDS];

   logic              accept;
   logic [IDX_W-1:0]  idx;
   logic [31:0]       mem_word;
   logic [31:0]       load_data;
   logic [31:0]       merged_word;
   logic              range_err;
   logic              align_err;
   logic              access_err;
   logic [31:0]       rsp_data;

   assign accept    = (state == IDLE) && req_valid;
   assign idx       = h_addr[IDX_W+1:2];
   assign mem_word  = mem[idx];
   assign range_err = h_addr[31:2] >= 30'(DEPTH_WORDS);

`ifdef MEM_RESP_ALIGN_CHECK_EN
   assign align_err = misaligned(h_mode, h_addr[1:0]);
`else
   assign align_err = 1'b0;
`endif

   assign access_err = range_err || align_err;
   assign rsp_data   = (h_write || access_err) ? '0 : load_data;

   mem_resp_lane_unit u_lane (
      .mode        (h_mode),
      .addr_lo     (h_addr[1:0]),
      .mem_word    (mem_word),
      .store_data  (h_wdata),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req_valid) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
         WAIT:    if (cnt == '0) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      req_ready      = (state == IDLE);
      resp_valid     = (state == RESP);
      resp_error     = resp_valid && access_err;
      resp_read_data = resp_valid ? rsp_data : held_rdata;
   end

   // Holding registers, wait counter and the held response word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         h_write    <= 1'b0;
         h_mode     <= MODE_WORD;
         h_addr     <= '0;
         h_wdata    <= '0;
         held_rdata <= '0;
      end else begin
         if (accept) begin
            h_write <= req_write;
            h_mode  <= load_mode_e'(req_load_mode);
            h_addr  <= req_address;
            h_wdata <= req_write_data;
            cnt     <= CNT_LOAD;
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (state == RESP) held_rdata <= rsp_data;
      end
   end

   // NOTE: storage is deliberately left out of reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (state == RESP && h_write && !access_err) mem[idx] <= merged_word;
   end

endmodule

// File: tb/tb_mem_data_responder.sv
// Scoreboard bench for mem_data_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares data, error and latency.
module tb_mem_data_responder;
   import mem_resp_pkg::*;

   localparam int DEPTH_WORDS = 256;
   localparam int WAIT_STATES = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_load_mode = 2'b00;
   logic [31:0] req_address = '0;
   logic [31:0] req_write_data = '0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_read_data;
   logic        resp_error;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        err;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   mem_data_responder #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .WAIT_STATES (WAIT_STATES)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_load_mode  (req_load_mode),
      .req_address    (req_address),
      .req_write_data (req_write_data),
      .resp_valid     (resp_valid),
      .resp_read_data (resp_read_data),
      .resp_error     (resp_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && resp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: got data=%h err=%b expected no response", resp_read_data, resp_error);
         end else begin
            e = sb.pop_front();
            check({e.name, "_data"}, resp_read_data, e.data);
            check({e.name, "_err"}, {31'b0, resp_error}, {31'b0, e.err});
            check({e.name, "_latency"}, cyc, e.due);
         end
      end
   end

   task automatic issue(input string name, input logic wr, input logic [1:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err);
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $display("FAIL %s_ready_timeout: got req_ready=0 expected 1", name);
         return;
      end
      req_valid      = 1'b1;
      req_write      = wr;
      req_load_mode  = mode;
      req_address    = addr;
      req_write_data = wdata;
      sb.push_back('{name, exp_data, exp_err, cyc + WAIT_STATES + 1});
      @(posedge clk);
      #1;
      // Scramble the request fields while busy; the responder must ignore them.
      req_valid      = 1'b0;
      req_write      = ~wr;
      req_load_mode  = ~mode;
      req_address    = 32'h0000_0010;
      req_write_data = 32'hA5A5_A5A5;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_resp_timeout: got no resp_valid expected one", name);
         sb.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_error", {31'b0, resp_error}, 32'd0);
      check("rst_rdata", resp_read_data, 32'h0);
      rst_n = 1'b1;

      issue("st_w_10",   1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0);
      issue("ld_w_10",   1'b0, 2'b00, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0);
      issue("ld_bs_11",  1'b0, 2'b10, 32'h11, 32'h0,         32'hFFFF_FFBE, 1'b0);
      issue("ld_bu_11",  1'b0, 2'b11, 32'h11, 32'h0,         32'h0000_00BE, 1'b0);
      issue("ld_hs_12",  1'b0, 2'b01, 32'h12, 32'h0,         32'hFFFF_DEAD, 1'b0);
      issue("st_b_13",   1'b1, 2'b10, 32'h13, 32'h0000_0055, 32'h0,         1'b0);
      issue("ld_w_10b",  1'b0, 2'b00, 32'h10, 32'h0,         32'h55AD_BEEF, 1'b0);
      repeat (3) @(negedge clk);
      check("hold_rdata", resp_read_data, 32'h55AD_BEEF);

      issue("st_w_0",    1'b1, 2'b00, 32'h0,   32'hCAFE_F00D, 32'h0,        1'b0);
      issue("ld_oor",    1'b0, 2'b00, 32'(4*DEPTH_WORDS), 32'h0, 32'h0,     1'b1);
      issue("st_oor",    1'b1, 2'b00, 32'(4*DEPTH_WORDS), 32'h1357_9BDF, 32'h0, 1'b1);
      issue("ld_w_0",    1'b0, 2'b00, 32'h0,   32'h0,         32'hCAFE_F00D, 1'b0);

`ifdef MEM_RESP_ALIGN_CHECK_EN
      issue("ld_w_12",   1'b0, 2'b00, 32'h12, 32'h0,         32'h0,         1'b1);
`else
      issue("ld_w_12",   1'b0, 2'b00, 32'h12, 32'h0,         32'h55AD_BEEF, 1'b0);
`endif

      issue("st_w_20",   1'b1, 2'b00, 32'h20, 32'h1111_1111, 32'h0,         1'b0);
      issue("ld_w_20",   1'b0, 2'b00, 32'h20, 32'h0,         32'h1111_1111, 1'b0);

      // Store abandoned by reset while in WAIT.
      @(negedge clk);
      req_valid      = 1'b1;
      req_write      = 1'b1;
      req_load_mode  = 2'b00;
      req_address    = 32'h20;
      req_write_data = 32'h1234_5678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("busy_req_ready", {31'b0, req_ready}, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
      check("midrst_rdata", resp_read_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      issue("ld_w_20_rst", 1'b0, 2'b00, 32'h20, 32'h0,        32'h1111_1111, 1'b0);
      issue("st_h_22",     1'b1, 2'b01, 32'h22, 32'h0000_BEEF, 32'h0,        1'b0);
      issue("ld_w_20_h",   1'b0, 2'b00, 32'h20, 32'h0,        32'hBEEF_1111, 1'b0);
      issue("ld_hs_22",    1'b0, 2'b01, 32'h22, 32'h0,        32'hFFFF_BEEF, 1'b0);

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL pending_resp: got %0d outstanding expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
